// File: rtl/spi_arbiter_pkg.sv
// Shared state encoding and field widths for the SPI arbiter and its sub-blocks.
package spi_arb_pkg;

   localparam int CNT_W  = 4;   // byte count minus one, also wide enough for the gap counter
   localparam int DATA_W = 8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARB,
      S_LOAD,
      S_START,
      S_WAIT_BUSY,
      S_WAIT_DONE,
      S_GAP,
      S_RELEASE
   } state_t;

endpackage

// File: rtl/spi_arbiter_rr.sv
// Round-robin pick: first set request at or after the pointer, wrapping; zero-cycle decision.
// Pointer moves past the winner only when the caller accepts the grant (adv).
module rr_arbiter
   import spi_arb_pkg::*;
#(
   parameter  int NUM_REQ = 4,
   localparam int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req,
   input  logic               adv,
   output logic               any,
   output logic [IDX_W-1:0]   win_idx,
   output logic [NUM_REQ-1:0] win_oh
);

   localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_REQ - 1);

   logic [IDX_W-1:0] ptr_q, ptr_d, scan;

   always_comb begin
      any     = 1'b0;
      win_idx = ptr_q;
      scan    = ptr_q;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!any && req[scan]) begin
            any     = 1'b1;
            win_idx = scan;
         end
         scan = (scan == LAST) ? '0 : scan + 1'b1;
      end
      win_oh = any ? (NUM_REQ'(1) << win_idx) : '0;
   end

   always_comb begin
      ptr_d = ptr_q;
      if (adv && any) begin
         ptr_d = (win_idx == LAST) ? '0 : win_idx + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) ptr_q <= '0;
      else      ptr_q <= ptr_d;
   end

endmodule

// File: rtl/spi_arbiter.sv
// Shares one single-byte SPI master among NUM_REQ requesters, one frame of 1..16 bytes per grant.
// Grant 2 cycles after request; requesters wait without preemption. SPI_ARB_TIMEOUT_EN adds a start timeout.
module spi_arbiter
   import spi_arb_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int GAP_CYCLES = 2,
   parameter int TIMEOUT    = 64
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [CNT_W*NUM_REQ-1:0]  req_len,
   input  logic [DATA_W*NUM_REQ-1:0] req_data,
   output logic [NUM_REQ-1:0]        data_rd,
   output logic [NUM_REQ-1:0]        gnt,
   output logic [NUM_REQ-1:0]        done,
   output logic                      err,
   output logic                      busy,
   output logic                      spi_en,
   output logic [DATA_W-1:0]         spi_data,
   input  logic                      spi_ss
);

   localparam int IDX_W = $clog2(NUM_REQ);

   if (NUM_REQ < 2 || NUM_REQ > 8 || GAP_CYCLES < 1 || GAP_CYCLES > 15 || TIMEOUT < 1) begin : g_param_check
      $error("spi_arbiter: parameter out of range");
   end

   state_t             state_q, state_d;
   logic [NUM_REQ-1:0] gnt_q, gnt_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [CNT_W-1:0]   gap_q, gap_d;
   logic [DATA_W-1:0]  spi_data_q, spi_data_d;

   logic               arb_adv, arb_any;
   logic [IDX_W-1:0]   arb_idx;
   logic [NUM_REQ-1:0] arb_oh;

   logic [CNT_W-1:0]   len_arr [NUM_REQ];
   logic [DATA_W-1:0]  dat_arr [NUM_REQ];

`ifdef SPI_ARB_TIMEOUT_EN
   localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   logic [TO_W-1:0] to_q, to_d;
`endif

   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         len_arr[i] = req_len[i*CNT_W +: CNT_W];
         dat_arr[i] = req_data[i*DATA_W +: DATA_W];
      end
   end

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .adv     (arb_adv),
      .any     (arb_any),
      .win_idx (arb_idx),
      .win_oh  (arb_oh)
   );

   // The byte is captured on entry to LOAD so data_rd can let the requester move on immediately.
   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      idx_d      = idx_q;
      cnt_d      = cnt_q;
      gap_d      = gap_q;
      spi_data_d = spi_data_q;
      arb_adv    = 1'b0;
      err        = 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
      to_d       = to_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (|req) state_d = S_ARB;
         end
         S_ARB: begin
            if (arb_any) begin
               arb_adv    = 1'b1;
               gnt_d      = arb_oh;
               idx_d      = arb_idx;
               cnt_d      = len_arr[arb_idx];
               spi_data_d = dat_arr[arb_idx];
               state_d    = S_LOAD;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_LOAD: state_d = S_START;
         S_START: begin
            state_d = S_WAIT_BUSY;
`ifdef SPI_ARB_TIMEOUT_EN
            to_d    = '0;
`endif
         end
         S_WAIT_BUSY: begin
            if (!spi_ss) state_d = S_WAIT_DONE;
`ifdef SPI_ARB_TIMEOUT_EN
            else if (to_q == TO_W'(TIMEOUT - 1)) begin
               err     = 1'b1;
               state_d = S_RELEASE;
            end else begin
               to_d = to_q + 1'b1;
            end
`endif
         end
         S_WAIT_DONE: begin
            if (spi_ss) begin
               if (cnt_q == '0 || !req[idx_q]) begin
                  state_d = S_RELEASE;
               end else begin
                  cnt_d   = cnt_q - 1'b1;
                  gap_d   = '0;
                  state_d = S_GAP;
               end
            end
         end
         S_GAP: begin
            if (gap_q == CNT_W'(GAP_CYCLES - 1)) begin
               spi_data_d = dat_arr[idx_q];
               state_d    = S_LOAD;
            end else begin
               gap_d = gap_q + 1'b1;
            end
         end
         S_RELEASE: begin
            gnt_d   = '0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         gnt_q      <= '0;
         idx_q      <= '0;
         cnt_q      <= '0;
         gap_q      <= '0;
         spi_data_q <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
         to_q       <= '0;
`endif
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         idx_q      <= idx_d;
         cnt_q      <= cnt_d;
         gap_q      <= gap_d;
         spi_data_q <= spi_data_d;
`ifdef SPI_ARB_TIMEOUT_EN
         to_q       <= to_d;
`endif
      end
   end

   assign gnt      = gnt_q;
   assign data_rd  = (state_q == S_LOAD)    ? gnt_q : '0;
   assign done     = (state_q == S_RELEASE) ? gnt_q : '0;
   assign busy     = (state_q != S_IDLE);
   assign spi_en   = (state_q != S_START);
   assign spi_data = spi_data_q;

endmodule

// File: tb/tb_spi_arbiter.sv
// Bench for spi_arbiter: behavioural SPI master and requesters, byte/done scoreboards, frame table.
module tb_spi_arbiter;

   localparam int N   = 4;
   localparam int GAP = 2;
   localparam int TMO = 64;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req;
   logic [4*N-1:0] req_len;
   logic [8*N-1:0] req_data;
   logic [N-1:0]   data_rd, gnt, done;
   logic           err, busy, spi_en;
   logic [7:0]     spi_data;
   logic           spi_ss;

   spi_arbiter #(.NUM_REQ(N), .GAP_CYCLES(GAP), .TIMEOUT(TMO)) dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .req_len  (req_len),
      .req_data (req_data),
      .data_rd  (data_rd),
      .gnt      (gnt),
      .done     (done),
      .err      (err),
      .busy     (busy),
      .spi_en   (spi_en),
      .spi_data (spi_data),
      .spi_ss   (spi_ss)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         r;
      logic [7:0] b;
   } exp_t;

   typedef struct {
      int         r;
      int         len;
      logic [7:0] b0;
      logic [7:0] step;
      int         exp_rd;
   } vec_t;

   exp_t       sbq[$];
   int         doneq[$];
   logic [7:0] mem [N][16];
   logic [3:0] pos [N];
   int         rd_cnt [N];

   int total = 0;
   int bad   = 0;
   int m_cnt = 0, rise_cyc = -1, last_start_cyc = -1;
   int first_rd = -1, first_start = -1;
   int starts = 0, starts_in_frame = 0;
   int done_total = 0, done_cyc = -1, err_cnt = 0, err_cyc = -1;
   bit mute = 1'b0, en_prev_low = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
      end
   endtask

   task automatic refresh();
      for (int r = 0; r < N; r++) req_data[r*8 +: 8] = mem[r][pos[r]];
   endtask

   task automatic load(input int r, input int len, input logic [7:0] b0, input logic [7:0] step, input int npush);
      for (int k = 0; k < 16; k++) mem[r][k] = 8'(b0 + 8'(k) * step);
      pos[r] = 4'd0;
      req_len[r*4 +: 4] = 4'(len);
      refresh();
      for (int k = 0; k < npush; k++) sbq.push_back('{r, 8'(b0 + 8'(k) * step)});
   endtask

   task automatic wait_done(input int target, input int limit);
      int n = 0;
      while (done_total < target && n < limit) begin
         @(negedge clk); #1;
         n++;
      end
      check("done_wait", done_total >= target, 1);
   endtask

   task automatic run_frame(input vec_t v);
      int rd0, s0, base, raise;
      load(v.r, v.len, v.b0, v.step, v.len + 1);
      doneq.push_back(v.r);
      rd0 = rd_cnt[v.r]; s0 = starts; base = done_total;
      @(negedge clk); #1;
      first_rd = -1; first_start = -1;
      raise = cyc;
      req[v.r] = 1'b1;
      wait_done(base + 1, 2000);
      check("frame_rd_count", rd_cnt[v.r] - rd0, v.exp_rd);
      check("frame_starts", starts - s0, v.exp_rd);
      check("rd_latency", first_rd - raise, 2);
      check("start_latency", first_start - raise, 3);
      @(negedge clk); #1;
      check("busy_after_frame", busy, 0);
   endtask

   // Behavioural master, requesters and output scoreboards, all sampled on the falling edge.
   initial begin
      exp_t e;
      int   d;
      forever begin
         @(negedge clk);
         if (m_cnt > 0) begin
            m_cnt++;
            if (m_cnt == 3) spi_ss = 1'b0;
            if (m_cnt == 6) begin
               spi_ss = 1'b1; m_cnt = 0; rise_cyc = cyc;
            end
         end
         if (!spi_en) begin
            check("start_while_master_busy", m_cnt, 0);
            check("spi_en_width", en_prev_low, 0);
            if (starts_in_frame > 0) check("gap_after_ss_rise", (cyc - rise_cyc) >= GAP, 1);
            check("byte_sb_nonempty", sbq.size() > 0, 1);
            if (sbq.size() > 0) begin
               e = sbq.pop_front();
               check("start_gnt", gnt, 1 << e.r);
               check("start_byte", spi_data, e.b);
            end
            starts++; starts_in_frame++; last_start_cyc = cyc;
            if (first_start < 0) first_start = cyc;
            if (!mute) m_cnt = 1;
         end
         en_prev_low = !spi_en;
         for (int r = 0; r < N; r++) begin
            if (data_rd[r]) begin
               rd_cnt[r]++;
               if (pos[r] != 4'd15) pos[r] = pos[r] + 4'd1;
            end
         end
         if (data_rd != '0 && first_rd < 0) first_rd = cyc;
         refresh();
         if (done != '0) begin
            done_total++; done_cyc = cyc;
            check("done_sb_nonempty", doneq.size() > 0, 1);
            if (doneq.size() > 0) begin
               d = doneq.pop_front();
               check("done_id", done, 1 << d);
            end
            if (rise_cyc > last_start_cyc) check("done_after_ss_rise", cyc - rise_cyc, 1);
            req = req & ~done;
            starts_in_frame = 0;
         end
         if (err) begin
            err_cnt++; err_cyc = cyc;
         end
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[4];
      int   n, rd0, s0, base;
      tbl[0] = '{0, 0,  8'hA5, 8'h00, 1};
      tbl[1] = '{1, 2,  8'h11, 8'h11, 3};
      tbl[2] = '{3, 15, 8'h00, 8'h01, 16};
      tbl[3] = '{2, 1,  8'hF0, 8'h01, 2};

      rst = 1'b0; req = '0; req_len = '0; req_data = '0; spi_ss = 1'b1;
      for (int r = 0; r < N; r++) begin pos[r] = 4'd0; rd_cnt[r] = 0; end
      #12;
      check("rst_gnt", gnt, 0);
      check("rst_data_rd", data_rd, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_busy", busy, 0);
      check("rst_spi_en", spi_en, 1);
      check("rst_spi_data", spi_data, 0);

      // All four requesting out of reset, twice: order 0,1,2,3 both rounds.
      for (int rnd = 0; rnd < 2; rnd++) begin
         for (int r = 0; r < N; r++) begin
            load(r, 0, 8'(8'h40 + 8'(r) + 8'(rnd * 16)), 8'h00, 1);
            doneq.push_back(r);
         end
         req = '1;
         if (rnd == 0) begin
            @(negedge clk); rst = 1'b1;
         end
         wait_done((rnd + 1) * N, 600);
         repeat (2) @(negedge clk);
         #1;
      end

      foreach (tbl[i]) run_frame(tbl[i]);

      // Requester 2 drops out while its second of four bytes is in flight.
      load(2, 3, 8'h21, 8'h01, 2);
      doneq.push_back(2);
      rd0 = rd_cnt[2]; s0 = starts; base = done_total;
      @(negedge clk); #1;
      req[2] = 1'b1;
      n = 0;
      while (rd_cnt[2] - rd0 < 2 && n < 300) begin @(negedge clk); #1; n++; end
      n = 0;
      while (spi_ss && n < 100) begin @(negedge clk); #1; n++; end
      check("drop_ss_low", spi_ss, 0);
      req[2] = 1'b0;
      wait_done(base + 1, 300);
      repeat (10) @(negedge clk);
      #1;
      check("drop_rd_count", rd_cnt[2] - rd0, 2);
      check("drop_starts", starts - s0, 2);
      check("drop_busy", busy, 0);

      // Reset while a byte is in flight, then pointer restarts at 0.
      load(1, 5, 8'h51, 8'h01, 1);
      rd0 = rd_cnt[1];
      @(negedge clk); #1;
      req[1] = 1'b1;
      n = 0;
      while (spi_ss && n < 100) begin @(negedge clk); #1; n++; end
      check("rst_test_ss_low", spi_ss, 0);
      @(negedge clk); #1;
      rst = 1'b0; req = '0;
      #1;
      check("midrst_gnt", gnt, 0);
      check("midrst_spi_en", spi_en, 1);
      check("midrst_busy", busy, 0);
      check("midrst_spi_data", spi_data, 0);
      check("midrst_rd_count", rd_cnt[1] - rd0, 1);
      starts_in_frame = 0;
      n = 0;
      while (!spi_ss && n < 100) begin @(negedge clk); #1; n++; end
      @(negedge clk); #1;
      rst = 1'b1;
      load(0, 0, 8'h61, 8'h00, 1);
      load(2, 0, 8'h62, 8'h00, 1);
      doneq.push_back(0); doneq.push_back(2);
      base = done_total;
      @(negedge clk); #1;
      req = 4'b0101;
      wait_done(base + 2, 400);
      repeat (2) @(negedge clk);
      #1;

`ifdef SPI_ARB_TIMEOUT_EN
      mute = 1'b1;
      load(0, 0, 8'h77, 8'h00, 1);
      doneq.push_back(0);
      base = done_total; n = err_cnt;
      @(negedge clk); #1;
      first_start = -1;
      req[0] = 1'b1;
      wait_done(base + 1, 300);
      check("timeout_err_count", err_cnt - n, 1);
      check("timeout_err_latency", err_cyc - first_start, TMO);
      check("timeout_done_after_err", done_cyc - err_cyc, 1);
      @(negedge clk); #1;
      check("timeout_busy", busy, 0);
      mute = 1'b0;
`else
      check("err_never_pulsed", err_cnt, 0);
`endif

      check("byte_sb_drained", sbq.size(), 0);
      check("done_sb_drained", doneq.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/spi_arbiter.md
# spi_arbiter

Round-robin arbiter and byte sequencer that shares the single-byte SPI master (`spi`) between up to `NUM_REQ` requesters. Each requester asks for a frame of 1..16 bytes; the arbiter grants one requester at a time, feeds its bytes to the master one transaction at a time, and tracks completion through the master's `SS` line. It sits between the command/test logic and `spi`, and owns the master's `en`/`data_in` inputs exclusively.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `GAP_CYCLES`, 2: idle cycles inserted after `SS` rises before the next byte's start pulse, 1..15.
- `TIMEOUT`, 64: cycles allowed between start pulse and `SS` falling (used only with `SPI_ARB_TIMEOUT_EN`).
- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req`  in  NUM_REQ  frame request per requester; held high until its `done`.
- `req_len`  in  4*NUM_REQ  per-requester byte count minus one (0 = 1 byte, 15 = 16 bytes); sampled at grant.
- `req_data`  in  8*NUM_REQ  per-requester current byte.
- `data_rd`  out  NUM_REQ  one-cycle pulse: byte consumed; requester presents next byte by the following cycle.
- `gnt`  out  NUM_REQ  one-hot grant, held for the whole frame.
- `done`  out  NUM_REQ  one-cycle pulse at frame end.
- `err`  out  1  one-cycle pulse on start timeout (tied 0 without macro).
- `busy`  out  1  high in every state except IDLE.
- `spi_en`  out  1  active-low start to master.
- `spi_data`  out  8  byte to master.
- `spi_ss`  in  1  master slave-select; low = byte in flight.

## Operation
- Reset values: `gnt`=0, `data_rd`=0, `done`=0, `err`=0, `busy`=0, `spi_en`=1, `spi_data`=0; state IDLE; RR pointer=0; byte counter=0.
- States: IDLE -> ARB -> LOAD -> START -> WAIT_BUSY -> WAIT_DONE -> (GAP -> LOAD | RELEASE) ; RELEASE -> IDLE.
- IDLE: any `req` bit high -> ARB.
- ARB: pick first set `req` bit at or after pointer, wrapping; set `gnt`; latch `req_len` of winner into counter; pointer <- winner+1 mod NUM_REQ. If `req` all low (dropped) -> IDLE.
- LOAD: `spi_data` <- winner's `req_data`; pulse winner's `data_rd`.
- START: `spi_en`=0 for exactly one cycle; `spi_data` stable.
- WAIT_BUSY: wait `spi_ss`==0 -> WAIT_DONE.
- WAIT_DONE: wait `spi_ss`==1. Counter==0 or winner's `req` low -> RELEASE; else decrement counter -> GAP.
- GAP: count `GAP_CYCLES` then LOAD.
- RELEASE: pulse winner's `done`; clear `gnt`; -> IDLE.
- Requests arriving while busy wait; never preempt. Requester dropping `req` mid-frame: byte in flight completes, frame ends with `done` (abort), no further `data_rd`.
- `spi_data` holds last byte after frame end.
- Reset mid-frame: all outputs to reset values immediately; master left to finish on its own.

## Timing
- `req` high in IDLE at cycle 0: ARB cycle 1, `gnt` visible cycle 2, `data_rd` pulse cycle 2, `spi_en` low cycle 3.
- Per byte overhead beyond master time: LOAD + START + GAP_CYCLES + 1 edge-detect cycle each on SS fall/rise.
- `done` asserted the cycle after last `spi_ss` rise observed; next ARB earliest two cycles after `done`.
- Counter arithmetic 4-bit unsigned, no wrap: decrement only when nonzero.

## Configuration
- `SPI_ARB_TIMEOUT_EN` defined: WAIT_BUSY has a counter; `spi_ss` not low within `TIMEOUT` cycles of start -> `err` pulse, RELEASE with `done` pulse, frame abandoned.
- Undefined: WAIT_BUSY waits indefinitely; `err` tied 0; no counter logic.

## Structure
- Package `spi_arb_pkg`: state encoding constants, byte-count width (4), data width (8).
- Sub-module `rr_arbiter`: combinational first-set-at-or-after-pointer search plus registered pointer; parameterised on `NUM_REQ`.

## Test plan
- Single req[0], len=0, data 0xA5 -> one `spi_en` pulse, `spi_data`=0xA5, one `data_rd[0]`, `done[0]` after SS rises, `busy` low after.
- req[1] len=2, data 0x11,0x22,0x33 -> three start pulses each ≥GAP_CYCLES after SS rise, bytes in order, exactly three `data_rd[1]`.
- req[0..3] all high from reset, len=0 each -> grants in order 0,1,2,3; re-raise all -> order 0,1,2,3 again (pointer wraps).
- req[2] dropped during second of four bytes -> second byte completes, `done[2]` pulses, no third `data_rd`.
- With `SPI_ARB_TIMEOUT_EN`, `spi_ss` held high -> `err` pulse exactly TIMEOUT cycles after start, `done` pulse, state IDLE.
- `rst` low during WAIT_DONE -> `gnt`=0, `spi_en`=1, `busy`=0 same cycle; after release, new req served from pointer 0.
